nn_sweep_checker: RTL and testbench

Synthesizable exhaustive-sweep checker for small combinational logic blocks (N_IN inputs, one output) built from delayed transistor-level gates. On `start` it drives every input vector 0 to 2**N_IN-1 onto the device under test and waits a programmable settle time. It then samples the synchronized response and compares it against a truth-table parameter, reporting the mismatch count and the first failing vector. It is the response-side counterpart to the free-running stimulus benches. The sweep is deterministic and self-checking, so a single `done`/`pass` pair replaces waveform inspection.

---
 rtl/nn_check_pkg.sv | 9 +
 rtl/nn_sweep_checker_resp_sync.sv | 21 ++
 rtl/nn_sweep_checker.sv | 117 +++++++++++
 tb/tb_nn_sweep_checker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nn_check_pkg.sv
// Shared types and constants for the exhaustive-sweep response checker.
package nn_check_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;

    localparam int unsigned SETTLE_MIN     = 3;
    localparam int unsigned SETTLE_DEFAULT = 8;

endpackage

// File: rtl/nn_sweep_checker_resp_sync.sv
// Two-flop synchronizer for the asynchronous DUT response.
module resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/nn_sweep_checker.sv
// Exhaustive-sweep checker: steps stim through every input vector, waits SETTLE
// cycles, then compares the synchronized response against the EXPECTED truth table.
module nn_sweep_checker
    import nn_check_pkg::*;
#(
    parameter int unsigned          N_IN     = 4,
    parameter int unsigned          SETTLE   = SETTLE_DEFAULT,
    parameter logic [2**N_IN-1:0]   EXPECTED = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int unsigned CW   = $clog2(SETTLE);
    localparam int unsigned ErrW = N_IN + 1;

    if (SETTLE < SETTLE_MIN) begin : g_settle_check
        $error("SETTLE must be at least %0d", SETTLE_MIN);
    end

    // Enumerators are package-qualified: the SETTLE parameter shadows the state name.
    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            resp_s;

    resp_sync u_resp_sync (
        .clk (clk),
        .rst (rst),
        .d   (resp),
        .q   (resp_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= nn_check_pkg::IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        case (state_q)
            nn_check_pkg::IDLE, nn_check_pkg::DONE: begin
                if (start) begin
                    state_d = nn_check_pkg::SETTLE;
                    stim_d  = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                end
            end
            nn_check_pkg::SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = nn_check_pkg::SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            nn_check_pkg::SAMPLE: begin
                if (resp_s != EXPECTED[stim_q]) begin
                    err_d = err_q + ErrW'(1);
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        ff_d = stim_q;
                    end
                end
                if (&stim_q) begin
                    state_d = nn_check_pkg::DONE;
                end else begin
                    state_d = nn_check_pkg::SETTLE;
                    stim_d  = stim_q + N_IN'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = nn_check_pkg::IDLE;
        endcase
    end

    assign stim           = stim_q;
    assign busy           = (state_q == nn_check_pkg::SETTLE) || (state_q == nn_check_pkg::SAMPLE);
    assign done           = (state_q == nn_check_pkg::DONE);
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_vec = ff_q;

endmodule

// File: tb/tb_nn_sweep_checker.sv
// Directed bench: two checkers (SETTLE=8 and SETTLE=24) against a delayed NAND4 model.
module tb_nn_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       resp_a, resp_b;
    logic [3:0] stim_a, stim_b, ff_a, ff_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
    logic [4:0] err_a, err_b;

    int compared   = 0;
    int mismatched = 0;
    int mode       = 0;  // 0: NAND4, 1: stuck at 1, 2: stuck at 0
    int dly        = 3;
    int n;

    logic [31:0] pipe_a = '0;
    logic [31:0] pipe_b = '0;

    always #5 clk = ~clk;

    function automatic logic model(input logic [3:0] v, input int m);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return ~&v;
    endfunction

    always @(posedge clk) begin
        pipe_a <= {pipe_a[30:0], model(stim_a, mode)};
        pipe_b <= {pipe_b[30:0], model(stim_b, mode)};
    end
    assign resp_a = pipe_a[dly-1];
    assign resp_b = pipe_b[dly-1];

    nn_sweep_checker #(.N_IN(4), .SETTLE(8), .EXPECTED(16'h7FFF)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .resp(resp_a), .stim(stim_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .first_fail_vec(ff_a)
    );

    nn_sweep_checker #(.N_IN(4), .SETTLE(24), .EXPECTED(16'h7FFF)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .resp(resp_b), .stim(stim_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .first_fail_vec(ff_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the first negedge after the accepting posedge.
    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // cycles = posedges from the accepting edge until done is seen.
    task automatic wait_done(input bit sel, output int cycles);
        cycles = 0;
        while (!(sel ? done_b : done_a) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_stim", 32'(stim_a), 32'h0);
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_done", 32'(done_a), 32'h0);
        check("reset_pass", 32'(pass_a), 32'h0);
        check("reset_err", 32'(err_a), 32'h0);
        check("reset_fv", 32'(fv_a), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Correct NAND4
        pulse_start(1'b0);
        check("nand_busy_rise", 32'(busy_a), 32'h1);
        wait_done(1'b0, n);
        check("nand_cycles", 32'(n), 32'd144);
        check("nand_pass", 32'(pass_a), 32'h1);
        check("nand_err", 32'(err_a), 32'h0);
        check("nand_fv", 32'(fv_a), 32'h0);
        check("nand_stim_hold", 32'(stim_a), 32'hF);
        check("nand_busy_done", 32'(busy_a), 32'h0);

        // Stuck at 1: only vector F mismatches
        mode = 1;
        pulse_start(1'b0);
        wait_done(1'b0, n);
        check("s1_err", 32'(err_a), 32'd1);
        check("s1_first", 32'(ff_a), 32'hF);
        check("s1_fv", 32'(fv_a), 32'h1);
        check("s1_pass", 32'(pass_a), 32'h0);

        // Stuck at 0: vectors 0..E mismatch
        mode = 2;
        pulse_start(1'b0);
        wait_done(1'b0, n);
        check("s0_err", 32'(err_a), 32'd15);
        check("s0_first", 32'(ff_a), 32'h0);
        check("s0_pass", 32'(pass_a), 32'h0);

        // Restart from DONE after a failing sweep
        mode = 0;
        pulse_start(1'b0);
        check("rs_done_drop", 32'(done_a), 32'h0);
        check("rs_err_clr", 32'(err_a), 32'h0);
        check("rs_fv_clr", 32'(fv_a), 32'h0);
        check("rs_busy", 32'(busy_a), 32'h1);
        wait_done(1'b0, n);
        check("rs_cycles", 32'(n), 32'd144);
        check("rs_pass", 32'(pass_a), 32'h1);

        // start while busy is ignored
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        check("busy_stim_before", 32'(stim_a), 32'h2);
        pulse_start(1'b0);
        check("busy_stim_after", 32'(stim_a), 32'h2);
        check("busy_still", 32'(busy_a), 32'h1);
        wait_done(1'b0, n);
        check("busy_cycles", 32'(21 + n), 32'd144);
        check("busy_pass", 32'(pass_a), 32'h1);

        // Reset mid-sweep at stim=5
        pulse_start(1'b0);
        n = 0;
        while (stim_a != 4'h5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach5", 32'(stim_a), 32'h5);
        rst = 1'b1;
        #1;
        check("mid_stim", 32'(stim_a), 32'h0);
        check("mid_busy", 32'(busy_a), 32'h0);
        check("mid_done", 32'(done_a), 32'h0);
        check("mid_err", 32'(err_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_idle", 32'(busy_a), 32'h0);
        pulse_start(1'b0);
        wait_done(1'b0, n);
        check("mid_cycles", 32'(n), 32'd144);
        check("mid_pass", 32'(pass_a), 32'h1);

        // Slow DUT: SETTLE=8 too short, SETTLE=24 sufficient
        dly = 20;
        pulse_start(1'b0);
        wait_done(1'b0, n);
        check("slow8_errnz", 32'(err_a > 5'd0), 32'h1);
        check("slow8_pass", 32'(pass_a), 32'h0);
        pulse_start(1'b1);
        wait_done(1'b1, n);
        check("slow24_cycles", 32'(n), 32'd400);
        check("slow24_pass", 32'(pass_b), 32'h1);
        check("slow24_err", 32'(err_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
